// File: rtl/voice_pkg.sv
// voice_pkg
// Shared definitions for the voice allocator slice:
//   - default sizing (voices, valid note range, forced key-off gap length)
//   - allocator FSM state enum
//   - per-slot record (active flag, held note, LRU age)
//   - 48-entry phase-increment table, INC(n) = round(130.81 * 2^(n/12) * 1.25)
package voice_pkg;

    localparam int NUM_VOICES_DEF = 4;
    localparam int NUM_NOTES_DEF  = 48;
    // Must stay above one LRCK period (384 clocks) so the codec sees the key-off.
    localparam int GAP_CYCLES_DEF = 400;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DECIDE = 2'd1,
        COMMIT = 2'd2,
        GAP    = 2'd3
    } state_t;

    // Age 0 is the most recently pressed voice; ages of active slots are unique.
    typedef struct packed {
        logic       active;
        logic [5:0] note;
        logic [1:0] age;
    } slot_t;

    // Index 0 = C3, 12 = C4, 21 = A4 (550), 47 = B6.
    localparam logic [15:0] INC_TABLE [NUM_NOTES_DEF] = '{
        16'd164,  16'd173,  16'd184,  16'd194,  16'd206,  16'd218,
        16'd231,  16'd245,  16'd260,  16'd275,  16'd291,  16'd309,
        16'd327,  16'd346,  16'd367,  16'd389,  16'd412,  16'd437,
        16'd462,  16'd490,  16'd519,  16'd550,  16'd583,  16'd617,
        16'd654,  16'd693,  16'd734,  16'd778,  16'd824,  16'd873,
        16'd925,  16'd980,  16'd1038, 16'd1100, 16'd1165, 16'd1235,
        16'd1308, 16'd1386, 16'd1468, 16'd1556, 16'd1648, 16'd1746,
        16'd1850, 16'd1960, 16'd2076, 16'd2200, 16'd2331, 16'd2469
    };

endpackage

// File: rtl/note_inc_rom.sv
// note_inc_rom
// Combinational note-index to phase-increment lookup.
// Ports:
//   iNote  in  6   note index (0..47 valid)
//   oInc   out 16  phase increment; 0 for indices outside the table
module note_inc_rom
    import voice_pkg::*;
(
    input  logic [5:0]  iNote,
    output logic [15:0] oInc
);

    always_comb begin
        oInc = 16'd0;
        case (iNote) inside
            [6'd0:6'd47]: oInc = INC_TABLE[iNote];
            default:      oInc = 16'd0;
        endcase
    end

endmodule

// File: rtl/voice_allocator.sv
// voice_allocator
// Turns note press/release events into four codec voice channels (key-on
// level + 16-bit phase increment). Handles free-slot allocation, retrigger,
// oldest-voice stealing with a forced key-off gap, and increment lookup.
// Ports:
//   iCLK_18_4            in   18.432 MHz clock
//   iRST                 in   asynchronous active-high reset
//   iEvt_valid/oEvt_ready     event handshake
//   iEvt_note   [5:0]    in   note index
//   iEvt_press           in   1 = press, 0 = release
//   iAll_off             in   synchronous level, clears all voices
//   oKey_on     [3:0]    out  per-slot key-on, bit0 = key1_on
//   oSound1..4  [15:0]   out  per-slot phase increment
//   oDrop                out  one-cycle pulse for an out-of-range note
module voice_allocator
    import voice_pkg::*;
#(
    parameter int NUM_VOICES = NUM_VOICES_DEF,
    parameter int NUM_NOTES  = NUM_NOTES_DEF,
    parameter int GAP_CYCLES = GAP_CYCLES_DEF
)(
    input  logic                  iCLK_18_4,
    input  logic                  iRST,
    input  logic                  iEvt_valid,
    output logic                  oEvt_ready,
    input  logic [5:0]            iEvt_note,
    input  logic                  iEvt_press,
    input  logic                  iAll_off,
    output logic [NUM_VOICES-1:0] oKey_on,
    output logic [15:0]           oSound1,
    output logic [15:0]           oSound2,
    output logic [15:0]           oSound3,
    output logic [15:0]           oSound4,
    output logic                  oDrop
);

    localparam int             CW         = $clog2(GAP_CYCLES);
    localparam logic [CW-1:0]  GAP_LOAD   = CW'(GAP_CYCLES - 1);
    localparam logic [5:0]     NOTE_LIMIT = 6'(NUM_NOTES);

    state_t                r_state, w_next;
    slot_t                 r_slots [NUM_VOICES];
    logic [NUM_VOICES-1:0] r_keyOn;
    logic [15:0]           r_sound [NUM_VOICES];
    logic [5:0]            r_note;
    logic                  r_press;
    logic [1:0]            r_target, w_target;
    logic [CW-1:0]         r_gapCnt;
    logic [15:0]           w_inc;
    logic                  w_ready, w_drop, w_accept;
    logic                  w_matchHit, w_freeHit;
    logic [1:0]            w_matchIdx, w_freeIdx, w_oldIdx, w_prevAge;

    note_inc_rom u_rom (
        .iNote (r_note),
        .oInc  (w_inc)
    );

    assign w_accept = iEvt_valid && w_ready;

    // Parallel slot scan; descending loop so the lowest index wins.
    always_comb begin
        w_matchHit = 1'b0;
        w_matchIdx = 2'd0;
        w_freeHit  = 1'b0;
        w_freeIdx  = 2'd0;
        w_oldIdx   = 2'd0;
        for (int i = NUM_VOICES - 1; i >= 0; i--) begin
            if (r_slots[i].active && r_slots[i].note == r_note) begin
                w_matchHit = 1'b1;
                w_matchIdx = 2'(i);
            end
            if (!r_slots[i].active) begin
                w_freeHit = 1'b1;
                w_freeIdx = 2'(i);
            end
            if (r_slots[i].active && r_slots[i].age == 2'd3) begin
                w_oldIdx = 2'(i);
            end
        end
    end

    // A free target ranks as the oldest possible age for the LRU shift.
    assign w_prevAge = r_slots[r_target].active ? r_slots[r_target].age : 2'd3;

    always_ff @(posedge iCLK_18_4 or posedge iRST) begin
        if (iRST) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next   = r_state;
        w_target = r_target;
        w_drop   = 1'b0;
        w_ready  = 1'b0;
        case (r_state)
            IDLE: begin
                w_ready = !iAll_off;
                if (iEvt_valid && !iAll_off) w_next = DECIDE;
            end
            DECIDE: begin
                w_next = IDLE;
                if (r_note >= NOTE_LIMIT) begin
                    w_drop = 1'b1;
                end else if (w_matchHit) begin
                    // Release of a held note, or retrigger of a held note.
                    w_target = w_matchIdx;
                    w_next   = COMMIT;
                end else if (r_press && w_freeHit) begin
                    w_target = w_freeIdx;
                    w_next   = COMMIT;
                end else if (r_press) begin
                    w_target = w_oldIdx;
                    w_next   = GAP;
                end
            end
            GAP: begin
                if (r_gapCnt == '0) w_next = COMMIT;
            end
            COMMIT: begin
                w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
        if (iAll_off) begin
            w_next = IDLE;
            w_drop = 1'b0;
        end
    end

    always_ff @(posedge iCLK_18_4 or posedge iRST) begin
        if (iRST) begin
            r_note   <= '0;
            r_press  <= 1'b0;
            r_target <= '0;
            r_gapCnt <= '0;
        end else begin
            if (w_accept) begin
                r_note  <= iEvt_note;
                r_press <= iEvt_press;
            end
            if (r_state == DECIDE) r_target <= w_target;
            if (r_state == DECIDE && w_next == GAP) begin
                r_gapCnt <= GAP_LOAD;
            end else if (r_state == GAP && r_gapCnt != '0) begin
                r_gapCnt <= r_gapCnt - CW'(1);
            end
        end
    end

    // Slot records, key-on levels and increments. A stolen slot keeps its
    // record through GAP; only its key-on level drops until COMMIT.
    always_ff @(posedge iCLK_18_4 or posedge iRST) begin
        if (iRST) begin
            r_keyOn <= '0;
            for (int i = 0; i < NUM_VOICES; i++) begin
                r_slots[i] <= '0;
                r_sound[i] <= '0;
            end
        end else if (iAll_off) begin
            r_keyOn <= '0;
            for (int i = 0; i < NUM_VOICES; i++) begin
                r_slots[i].active <= 1'b0;
                r_slots[i].age    <= 2'd0;
            end
        end else if (r_state == DECIDE && w_next == GAP) begin
            r_keyOn[w_target] <= 1'b0;
        end else if (r_state == COMMIT) begin
            if (r_press) begin
                r_keyOn[r_target] <= 1'b1;
                r_sound[r_target] <= w_inc;
                for (int i = 0; i < NUM_VOICES; i++) begin
                    if (2'(i) == r_target) begin
                        r_slots[i].active <= 1'b1;
                        r_slots[i].note   <= r_note;
                        r_slots[i].age    <= 2'd0;
                    end else if (r_slots[i].active && r_slots[i].age < w_prevAge) begin
                        r_slots[i].age <= r_slots[i].age + 2'd1;
                    end
                end
            end else begin
                r_keyOn[r_target] <= 1'b0;
                for (int i = 0; i < NUM_VOICES; i++) begin
                    if (2'(i) == r_target) begin
                        r_slots[i].active <= 1'b0;
                        r_slots[i].age    <= 2'd0;
                    end else if (r_slots[i].active && r_slots[i].age > w_prevAge) begin
                        r_slots[i].age <= r_slots[i].age - 2'd1;
                    end
                end
            end
        end
    end

    assign oEvt_ready = w_ready;
    assign oDrop      = w_drop;
    assign oKey_on    = r_keyOn;
    assign oSound1    = r_sound[0];
    assign oSound2    = r_sound[1];
    assign oSound3    = r_sound[2];
    assign oSound4    = r_sound[3];

endmodule

// File: tb/tb_voice_allocator.sv
// tb_voice_allocator
// Directed bench for voice_allocator: reset values, single press latency,
// fill/release, voice stealing with key-off gap, retrigger LRU, drop and
// unheld release, iAll_off mid-gap, asynchronous reset mid-gap/mid-decide.
module tb_voice_allocator;

    logic        clk = 1'b0;
    logic        rst, valid, press, allOff;
    logic [5:0]  note;
    logic        rdy, drop;
    logic [3:0]  keyOn;
    logic [15:0] snd1, snd2, snd3, snd4;

    int errors = 0;
    int checks = 0;

    voice_allocator dut (
        .iCLK_18_4  (clk),
        .iRST       (rst),
        .iEvt_valid (valid),
        .oEvt_ready (rdy),
        .iEvt_note  (note),
        .iEvt_press (press),
        .iAll_off   (allOff),
        .oKey_on    (keyOn),
        .oSound1    (snd1),
        .oSound2    (snd2),
        .oSound3    (snd3),
        .oSound4    (snd4),
        .oDrop      (drop)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic applyReset();
        @(negedge clk);
        rst = 1'b1; valid = 1'b0; note = 6'd0; press = 1'b0; allOff = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    // Presents one event at a negedge and returns 1 ns after the accepting edge.
    task automatic sendEvent(input logic [5:0] n, input logic p);
        int waitCnt;
        waitCnt = 0;
        @(negedge clk);
        while (!rdy && waitCnt < 1000) begin
            @(negedge clk);
            waitCnt++;
        end
        checks++;
        if (!rdy) begin
            errors++;
            $display("[TB] FAIL send_ready_timeout: ready=%0b required 1", rdy);
        end
        valid = 1'b1; note = n; press = p;
        @(posedge clk);
        #1 valid = 1'b0;
    endtask

    task automatic waitIdle();
        int waitCnt;
        waitCnt = 0;
        @(negedge clk);
        while (!rdy && waitCnt < 1000) begin
            @(negedge clk);
            waitCnt++;
        end
        checks++;
        if (!rdy) begin
            errors++;
            $display("[TB] FAIL idle_timeout: ready=%0b required 1", rdy);
        end
    endtask

    task automatic pressFour();
        sendEvent(6'd0, 1'b1);  waitIdle();
        sendEvent(6'd12, 1'b1); waitIdle();
        sendEvent(6'd21, 1'b1); waitIdle();
        sendEvent(6'd47, 1'b1); waitIdle();
    endtask

    task automatic test_reset();
        rst = 1'b1; valid = 1'b0; note = 6'd0; press = 1'b0; allOff = 1'b0;
        #3;
        checks++;
        if (keyOn !== 4'b0000) begin errors++; $display("[TB] FAIL reset_key: got %b required 0000", keyOn); end
        checks++;
        if ({snd1, snd2, snd3, snd4} !== 64'd0) begin errors++; $display("[TB] FAIL reset_sound: got %0d/%0d/%0d/%0d required 0", snd1, snd2, snd3, snd4); end
        checks++;
        if (rdy !== 1'b1) begin errors++; $display("[TB] FAIL reset_ready: got %b required 1", rdy); end
        checks++;
        if (drop !== 1'b0) begin errors++; $display("[TB] FAIL reset_drop: got %b required 0", drop); end
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_single_press();
        sendEvent(6'd21, 1'b1);
        @(negedge clk);   // DECIDE
        checks++;
        if (rdy !== 1'b0) begin errors++; $display("[TB] FAIL single_busy_ready: got %b required 0", rdy); end
        @(negedge clk);   // COMMIT
        checks++;
        if (keyOn !== 4'b0000) begin errors++; $display("[TB] FAIL single_early_key: got %b required 0000", keyOn); end
        @(negedge clk);   // two clocks after accept
        checks++;
        if (keyOn !== 4'b0001) begin errors++; $display("[TB] FAIL single_key: got %b required 0001", keyOn); end
        checks++;
        if (snd1 !== 16'd550) begin errors++; $display("[TB] FAIL single_sound1: got %0d required 550", snd1); end
        checks++;
        if (rdy !== 1'b1) begin errors++; $display("[TB] FAIL single_ready: got %b required 1", rdy); end
    endtask

    task automatic test_fill_release();
        applyReset();
        pressFour();
        checks++;
        if (keyOn !== 4'b1111) begin errors++; $display("[TB] FAIL fill_key: got %b required 1111", keyOn); end
        checks++;
        if ({snd1, snd2, snd3, snd4} !== {16'd164, 16'd327, 16'd550, 16'd2469})
            begin errors++; $display("[TB] FAIL fill_sound: got %0d/%0d/%0d/%0d required 164/327/550/2469", snd1, snd2, snd3, snd4); end
        sendEvent(6'd12, 1'b0);
        waitIdle();
        checks++;
        if (keyOn !== 4'b1101) begin errors++; $display("[TB] FAIL release_key: got %b required 1101", keyOn); end
        checks++;
        if (snd2 !== 16'd327) begin errors++; $display("[TB] FAIL release_hold_sound2: got %0d required 327", snd2); end
    endtask

    task automatic test_steal();
        int keyBad, rdyBad;
        keyBad = 0; rdyBad = 0;
        applyReset();
        pressFour();
        sendEvent(6'd5, 1'b1);
        @(negedge clk);   // DECIDE: key still on
        checks++;
        if (keyOn !== 4'b1111) begin errors++; $display("[TB] FAIL steal_decide_key: got %b required 1111", keyOn); end
        // 400 GAP cycles followed by the COMMIT cycle, all with slot0 keyed off.
        for (int k = 0; k < 401; k++) begin
            @(negedge clk);
            if (keyOn !== 4'b1110) keyBad++;
            if (rdy !== 1'b0) rdyBad++;
        end
        checks++;
        if (keyBad != 0) begin errors++; $display("[TB] FAIL steal_gap_key: bad samples %0d required 0", keyBad); end
        checks++;
        if (rdyBad != 0) begin errors++; $display("[TB] FAIL steal_gap_ready: bad samples %0d required 0", rdyBad); end
        @(negedge clk);   // GAP_CYCLES + 2 clocks after accept
        checks++;
        if (keyOn !== 4'b1111) begin errors++; $display("[TB] FAIL steal_key: got %b required 1111", keyOn); end
        // round(130.81 * 2^(5/12) * 1.25) = round(218.26) = 218
        checks++;
        if (snd1 !== 16'd218) begin errors++; $display("[TB] FAIL steal_sound1: got %0d required 218", snd1); end
        checks++;
        if ({snd2, snd3, snd4} !== {16'd327, 16'd550, 16'd2469})
            begin errors++; $display("[TB] FAIL steal_others: got %0d/%0d/%0d required 327/550/2469", snd2, snd3, snd4); end
        checks++;
        if (rdy !== 1'b1) begin errors++; $display("[TB] FAIL steal_ready: got %b required 1", rdy); end
    endtask

    task automatic test_retrigger();
        int keyBad;
        keyBad = 0;
        applyReset();
        pressFour();
        sendEvent(6'd0, 1'b1);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            if (keyOn !== 4'b1111) keyBad++;
        end
        checks++;
        if (keyBad != 0) begin errors++; $display("[TB] FAIL retrig_key_drop: bad samples %0d required 0", keyBad); end
        checks++;
        if (snd1 !== 16'd164) begin errors++; $display("[TB] FAIL retrig_sound1: got %0d required 164", snd1); end
        // Slot1 (note 12) is now the oldest and must be the steal victim.
        sendEvent(6'd30, 1'b1);
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (keyOn !== 4'b1101) begin errors++; $display("[TB] FAIL retrig_steal_victim: got %b required 1101", keyOn); end
        waitIdle();
        checks++;
        if (keyOn !== 4'b1111) begin errors++; $display("[TB] FAIL retrig_steal_key: got %b required 1111", keyOn); end
        checks++;
        if ({snd1, snd2} !== {16'd164, 16'd925}) begin errors++; $display("[TB] FAIL retrig_steal_sound: got %0d/%0d required 164/925", snd1, snd2); end
    endtask

    task automatic test_drop();
        sendEvent(6'd50, 1'b1);
        @(negedge clk);   // DECIDE
        checks++;
        if (drop !== 1'b1) begin errors++; $display("[TB] FAIL drop_pulse: got %b required 1", drop); end
        @(negedge clk);
        checks++;
        if (drop !== 1'b0) begin errors++; $display("[TB] FAIL drop_width: got %b required 0", drop); end
        checks++;
        if (rdy !== 1'b1) begin errors++; $display("[TB] FAIL drop_ready: got %b required 1", rdy); end
        checks++;
        if (keyOn !== 4'b1111) begin errors++; $display("[TB] FAIL drop_key: got %b required 1111", keyOn); end
        sendEvent(6'd3, 1'b0);
        @(negedge clk);
        checks++;
        if (drop !== 1'b0) begin errors++; $display("[TB] FAIL unheld_drop: got %b required 0", drop); end
        @(negedge clk);
        checks++;
        if (rdy !== 1'b1) begin errors++; $display("[TB] FAIL unheld_ready: got %b required 1", rdy); end
        checks++;
        if ({keyOn, snd1, snd2} !== {4'b1111, 16'd164, 16'd925})
            begin errors++; $display("[TB] FAIL unheld_state: got %b %0d/%0d required 1111 164/925", keyOn, snd1, snd2); end
    endtask

    task automatic test_all_off();
        applyReset();
        pressFour();
        sendEvent(6'd5, 1'b1);
        repeat (50) @(negedge clk);
        checks++;
        if (keyOn !== 4'b1110) begin errors++; $display("[TB] FAIL alloff_pre_gap: got %b required 1110", keyOn); end
        allOff = 1'b1;
        @(posedge clk);
        #1 allOff = 1'b0;
        @(negedge clk);
        checks++;
        if (keyOn !== 4'b0000) begin errors++; $display("[TB] FAIL alloff_key: got %b required 0000", keyOn); end
        checks++;
        if (rdy !== 1'b1) begin errors++; $display("[TB] FAIL alloff_ready: got %b required 1", rdy); end
        checks++;
        if ({snd1, snd2, snd3, snd4} !== {16'd164, 16'd327, 16'd550, 16'd2469})
            begin errors++; $display("[TB] FAIL alloff_sound: got %0d/%0d/%0d/%0d required 164/327/550/2469", snd1, snd2, snd3, snd4); end
        repeat (420) @(negedge clk);
        checks++;
        if ({keyOn, snd1} !== {4'b0000, 16'd164}) begin errors++; $display("[TB] FAIL alloff_no_late_commit: got %b %0d required 0000 164", keyOn, snd1); end
        sendEvent(6'd40, 1'b1);
        waitIdle();
        checks++;
        if ({keyOn, snd1} !== {4'b0001, 16'd1648}) begin errors++; $display("[TB] FAIL alloff_realloc: got %b %0d required 0001 1648", keyOn, snd1); end
    endtask

    task automatic test_async_reset();
        applyReset();
        pressFour();
        sendEvent(6'd5, 1'b1);
        repeat (20) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        checks++;
        if (keyOn !== 4'b0000) begin errors++; $display("[TB] FAIL areset_gap_key: got %b required 0000", keyOn); end
        checks++;
        if ({snd1, snd4} !== 32'd0) begin errors++; $display("[TB] FAIL areset_gap_sound: got %0d/%0d required 0/0", snd1, snd4); end
        checks++;
        if (rdy !== 1'b1) begin errors++; $display("[TB] FAIL areset_gap_ready: got %b required 1", rdy); end
        @(negedge clk);
        rst = 1'b0;
        sendEvent(6'd50, 1'b1);
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({rdy, drop} !== 2'b10) begin errors++; $display("[TB] FAIL areset_decide: got ready=%b drop=%b required ready=1 drop=0", rdy, drop); end
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single_press();
        test_fill_release();
        test_steal();
        test_retrigger();
        test_drop();
        test_all_off();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
